inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction fetch sequencer for the vector-processor sequencer. Drives the read port of the instruction ROM (`rden`/`addr`, fixed `COMMON_BRAM_DELAY` read latency, `o_vld`/`dout` return), tracks reads in flight, and buffers returned words in a small credit-controlled queue. The decoder receives the words through a valid/ready interface. Supports program start/end bounds and a jump that flushes in-flight and buffered instructions.

## Interface
- `DWIDTH`, `` `COE_WIDTH ``: instruction word width.
- `DEPTH`, `` `IQUEUE_DEPTH ``: ROM depth in words.
- `AWIDTH`, `$clog2(DEPTH)`: PC and address width.
- `COMMON_BRAM_DELAY`, `` `COMMON_BRAM_DELAY ``: ROM read latency D in cycles, D ≥ 1.
- `BUF_DEPTH`, `COMMON_BRAM_DELAY+2`: output queue depth. Must be ≥ D+1 to sustain 1 instruction per cycle.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: start pulse. Sampled in IDLE only.
- `start_pc` in AWIDTH: first PC. Sampled with `start`.
- `end_pc` in AWIDTH: last PC, inclusive. Sampled with `start`.
- `jmp_vld` in 1: jump request. Honoured in FETCH/DRAIN only.
- `jmp_pc` in AWIDTH: jump target.
- `busy` out 1: high in FETCH and DRAIN.
- `done` out 1: one-cycle pulse when the program completes.
- `rom_rden` out 1: ROM read enable.
- `rom_addr` out AWIDTH: ROM read address.
- `rom_vld` in 1: ROM read data valid.
- `rom_dout` in DWIDTH: ROM read data.
- `inst_vld` out 1: instruction valid.
- `inst_rdy` in 1: decoder ready.
- `inst_data` out DWIDTH: instruction word.
- `inst_pc` out AWIDTH: PC of `inst_data`.

## Operation
- **States:**
  - IDLE: on `start`, go to FETCH. Load `pc=start_pc`, latch `end_pc`.
  - FETCH: on issuing `end_pc`, go to DRAIN.
  - DRAIN: when outstanding==0, discard==0, queue empty, and no handshake is pending, go to IDLE with `done`=1 for one cycle.
- **Issue:** `rom_rden = (state==FETCH) && (outstanding + count < BUF_DEPTH)`, with `rom_addr = pc`.
  - On issue: `pc <= pc+1` (mod DEPTH), `outstanding++`.
  - `start_pc > end_pc` wraps through DEPTH-1 → 0.
- **Return:** on `rom_vld`, decrement `outstanding`.
  - If `discard>0`: drop the word and decrement `discard`.
  - Otherwise: push {`rom_dout`, return-PC} into the queue.
  - Return-PC comes from a D-deep PC shift register aligned with the ROM pipeline.
- **Credit rule:** the queue never overflows. A push when full is an assertion failure.
- **Output:** the queue head drives `inst_*`. A pop occurs on `inst_vld && inst_rdy`. Queue ordering is strictly PC-issue order.
- **Jump**, when `jmp_vld` in FETCH/DRAIN:
  - A handshake in the same cycle completes first.
  - The queue is cleared and `discard <= outstanding` (including any return arriving that cycle, which is dropped).
  - `pc <= jmp_pc`; state goes to FETCH, or DRAIN if `jmp_pc` lies outside the remaining [start…end_pc] window.
  - `jmp_pc == end_pc` issues that one word, then DRAIN.
- **Ignored requests:** `start` while busy, and `jmp_vld` in IDLE, are ignored.
- **Counter widths:** `outstanding` and `discard` are `$clog2(BUF_DEPTH+1)` bits. `count` is `$clog2(BUF_DEPTH+1)` bits.

## Timing
- **Reset values:** state=IDLE, pc=0, outstanding=discard=count=0. All outputs 0: `busy`, `done`, `rom_rden`, `rom_addr`, `inst_vld`, `inst_data`, `inst_pc`.
- **Reset mid-program:** returns to IDLE immediately. Late `rom_vld` after reset is ignored only if the ROM is reset together; both share `rst_n`.
- **Start latency:** `start` at cycle 0 → `rom_rden` at cycle 1 → `rom_vld` at 1+D → `inst_vld` at 2+D.
  - The queue is registered with no bypass.
- **Throughput:** 1 instruction/cycle while `inst_rdy` is held high.
- **Stall:** `inst_rdy` low for ≥ BUF_DEPTH cycles stops issue after BUF_DEPTH words total are held or in flight.
- **Jump latency:** `jmp_vld` at cycle t → first target read at t+1 → target `inst_vld` at t+2+D. Nothing stale appears after t.
- **Done timing:** `done` asserts the cycle after the last pop, together with `busy` falling.

## Structure
- **Shared header `vp_defines.vh`:** holds `COE_WIDTH`, `IQUEUE_DEPTH`, `COMMON_BRAM_DELAY`. Add `` `IFETCH_BUF_DEPTH `` there.
- **State encoding:** local 2-bit localparams (IDLE=0, FETCH=1, DRAIN=2).
- **Sub-module `inst_fetch_buf`:** synchronous FIFO, width DWIDTH+AWIDTH, depth BUF_DEPTH.
  - Provides push, pop, clear, count, head outputs.
  - Head outputs are registered.
  - Uses async active-low reset.
- **PC alignment pipeline:** use `gnrl_dff_r` instances for the D-deep PC/valid pipeline.

## Test plan
- **Sequential fetch:** D=2, ROM[i]=i+0x100, `start_pc=0`, `end_pc=7`, `inst_rdy=1` → `inst_vld` first at cycle 4. Then 8 consecutive words 0x100…0x107 with `inst_pc` 0…7, and `done` at cycle 12.
- **Backpressure:** `inst_rdy=0` for 20 cycles after start → `rom_rden` asserted exactly BUF_DEPTH=4 times. Then release → remaining words in order, no loss, no duplication.
- **Jump mid-stream:** `end_pc=15`, `jmp_vld` with `jmp_pc=10` while 2 reads are in flight and 1 word is queued → those 3 words are never presented. Next `inst_pc`=10, then 11…15, then `done`.
- **Wrap-around:** DEPTH=16, `start_pc=14`, `end_pc=1` → `inst_pc` sequence 14, 15, 0, 1, then `done`.
- **Ignored requests:** `start` pulsed while busy, and `jmp_vld` in IDLE → no state change, PCs unchanged.
- **Async reset mid-program:** assert `rst_n=0` mid-program → all outputs 0 within the same cycle, no `done`. A new `start` afterwards works normally.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and state type for the instruction fetch sequencer.
// Stands in for the vp_defines header values (COE_WIDTH, IQUEUE_DEPTH, COMMON_BRAM_DELAY).
package inst_fetch_ctrl_pkg;

    localparam int unsigned VP_COE_WIDTH        = 32;
    localparam int unsigned VP_IQUEUE_DEPTH     = 16;
    localparam int unsigned VP_BRAM_DELAY       = 2;
    localparam int unsigned VP_IFETCH_BUF_DEPTH = VP_BRAM_DELAY + 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/gnrl_dff_r.sv
// Generic resettable D flip-flop bank, used for the ROM-aligned PC pipeline.
module gnrl_dff_r #(
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Small synchronous shift-queue; entry 0 is always the head, so head outputs come
// straight from a register with no read mux. Clear has priority over push/pop.
module inst_fetch_buf #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_vld,
    output logic [WIDTH-1:0]             o_head
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_d;
    logic [CW-1:0]    w_widx;
    logic             w_pop_ok;
    logic             w_push_ok;

    always_comb begin
        w_mem_d   = r_mem;
        w_cnt_d   = r_cnt;
        w_pop_ok  = i_pop && (r_cnt != '0);
        w_widx    = r_cnt - CW'(w_pop_ok);
        w_push_ok = i_push && (w_widx < FULL_CNT);
        if (i_clear) begin
            w_cnt_d = '0;
        end else begin
            if (w_pop_ok) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    w_mem_d[i] = r_mem[i+1];
                end
            end
            if (w_push_ok) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == w_widx) begin
                        w_mem_d[i] = i_din;
                    end
                end
            end
            w_cnt_d = r_cnt - CW'(w_pop_ok) + CW'(w_push_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_mem <= w_mem_d;
            r_cnt <= w_cnt_d;
        end
    end

    assign o_count = r_cnt;
    assign o_vld   = (r_cnt != '0);
    assign o_head  = r_mem[0];

    // The credit rule upstream must keep a full queue from ever seeing a push.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_clear && (r_cnt == FULL_CNT) && !w_pop_ok));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: issues ROM reads under queue credit, aligns return PCs,
// buffers words for the decoder and handles jumps by flushing queued/in-flight words.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DWIDTH            = VP_COE_WIDTH,
    parameter int unsigned DEPTH             = VP_IQUEUE_DEPTH,
    parameter int unsigned AWIDTH            = $clog2(DEPTH),
    parameter int unsigned COMMON_BRAM_DELAY = VP_BRAM_DELAY,
    parameter int unsigned BUF_DEPTH         = COMMON_BRAM_DELAY + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [AWIDTH-1:0] i_start_pc,
    input  logic [AWIDTH-1:0] i_end_pc,
    input  logic              i_jmp_vld,
    input  logic [AWIDTH-1:0] i_jmp_pc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rom_rden,
    output logic [AWIDTH-1:0] o_rom_addr,
    input  logic              i_rom_vld,
    input  logic [DWIDTH-1:0] i_rom_dout,
    output logic              o_inst_vld,
    input  logic              i_inst_rdy,
    output logic [DWIDTH-1:0] o_inst_data,
    output logic [AWIDTH-1:0] o_inst_pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]       BUF_DEPTH_W = (CW+1)'(BUF_DEPTH);
    localparam logic [AWIDTH-1:0] LAST_PC     = AWIDTH'(DEPTH - 1);

    fetch_state_e      r_state, w_state_d;
    logic [AWIDTH-1:0] r_pc, w_pc_d;
    logic [AWIDTH-1:0] r_start_pc, w_start_pc_d;
    logic [AWIDTH-1:0] r_end_pc, w_end_pc_d;
    logic [CW-1:0]     r_outstanding, w_outstanding_d;
    logic [CW-1:0]     r_discard, w_discard_d;
    logic              r_done, w_done_d;

    logic [COMMON_BRAM_DELAY:0][AWIDTH-1:0] w_pc_pipe;
    logic [AWIDTH-1:0]        w_ret_pc;
    logic [CW-1:0]            w_count;
    logic                     w_q_vld;
    logic [DWIDTH+AWIDTH-1:0] w_head;
    logic                     w_busy, w_jump, w_issue, w_pop, w_push, w_drop;
    logic                     w_q_empty_d, w_jmp_in_win;
    logic [AWIDTH-1:0]        w_pc_inc, w_jmp_off, w_win_len;

    // PC of each issued read travels alongside the ROM pipeline and pops out with its data.
    assign w_pc_pipe[0] = r_pc;
    for (genvar g = 0; g < int'(COMMON_BRAM_DELAY); g++) begin : g_pc_dly
        gnrl_dff_r #(.DW(AWIDTH)) u_pc_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (w_pc_pipe[g]),
            .o_q   (w_pc_pipe[g+1])
        );
    end
    assign w_ret_pc = w_pc_pipe[COMMON_BRAM_DELAY];

    inst_fetch_buf #(
        .WIDTH (DWIDTH + AWIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({i_rom_dout, w_ret_pc}),
        .i_pop   (w_pop),
        .i_clear (w_jump),
        .o_count (w_count),
        .o_vld   (w_q_vld),
        .o_head  (w_head)
    );

    assign w_busy  = (r_state != StIdle);
    assign w_jump  = i_jmp_vld && w_busy;
    assign w_issue = (r_state == StFetch) &&
                     (({1'b0, r_outstanding} + {1'b0, w_count}) < BUF_DEPTH_W);
    assign w_pop   = w_q_vld && i_inst_rdy;
    assign w_drop  = i_rom_vld && (w_jump || (r_discard != '0));
    assign w_push  = i_rom_vld && !w_drop;

    assign w_outstanding_d = r_outstanding + CW'(w_issue) - CW'(i_rom_vld);
    assign w_q_empty_d     = !w_push && ((w_count == '0) || ((w_count == CW'(1)) && w_pop));
    assign w_pc_inc        = (r_pc == LAST_PC) ? '0 : r_pc + AWIDTH'(1);

    // Cyclic window test; modular AWIDTH arithmetic assumes DEPTH is a power of two.
    assign w_jmp_off    = i_jmp_pc - r_start_pc;
    assign w_win_len    = r_end_pc - r_start_pc;
    assign w_jmp_in_win = (w_jmp_off <= w_win_len);

    always_comb begin
        w_discard_d = r_discard;
        if (w_jump) begin
            w_discard_d = w_outstanding_d;
        end else if (i_rom_vld && (r_discard != '0)) begin
            w_discard_d = r_discard - CW'(1);
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_start_pc_d = r_start_pc;
        w_end_pc_d   = r_end_pc;
        w_done_d     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d    = StFetch;
                    w_pc_d       = i_start_pc;
                    w_start_pc_d = i_start_pc;
                    w_end_pc_d   = i_end_pc;
                end
            end
            StFetch: begin
                if (w_jump) begin
                    w_pc_d    = i_jmp_pc;
                    w_state_d = w_jmp_in_win ? StFetch : StDrain;
                end else if (w_issue) begin
                    w_pc_d = w_pc_inc;
                    if (r_pc == r_end_pc) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_jump) begin
                    w_pc_d    = i_jmp_pc;
                    w_state_d = w_jmp_in_win ? StFetch : StDrain;
                end else if ((w_outstanding_d == '0) && (w_discard_d == '0) && w_q_empty_d) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_pc          <= '0;
            r_start_pc    <= '0;
            r_end_pc      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_start_pc    <= w_start_pc_d;
            r_end_pc      <= w_end_pc_d;
            r_outstanding <= w_outstanding_d;
            r_discard     <= w_discard_d;
            r_done        <= w_done_d;
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = r_done;
    assign o_rom_rden  = w_issue;
    assign o_rom_addr  = r_pc;
    assign o_inst_vld  = w_q_vld;
    assign o_inst_data = w_head[DWIDTH+AWIDTH-1:AWIDTH];
    assign o_inst_pc   = w_head[AWIDTH-1:0];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: latency table, hand-written corner sequences and randomized
// programs with jumps, checked against a PC-list model of what the decoder must receive.
module tb_inst_fetch_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int D     = 2;
    localparam int BD    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start, i_jmp_vld, i_inst_rdy;
    logic [AW-1:0] i_start_pc, i_end_pc, i_jmp_pc;
    logic          o_busy, o_done, o_rom_rden, o_inst_vld;
    logic [AW-1:0] o_rom_addr, o_inst_pc;
    logic [DW-1:0] o_inst_data;
    logic          i_rom_vld;
    logic [DW-1:0] i_rom_dout;

    inst_fetch_ctrl #(
        .DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .COMMON_BRAM_DELAY(D), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_start_pc(i_start_pc),
        .i_end_pc(i_end_pc), .i_jmp_vld(i_jmp_vld), .i_jmp_pc(i_jmp_pc),
        .o_busy(o_busy), .o_done(o_done), .o_rom_rden(o_rom_rden), .o_rom_addr(o_rom_addr),
        .i_rom_vld(i_rom_vld), .i_rom_dout(i_rom_dout), .o_inst_vld(o_inst_vld),
        .i_inst_rdy(i_inst_rdy), .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc)
    );

    always #5 clk = ~clk;

    // ROM with a fixed D-cycle read latency, reset together with the DUT.
    logic [DW-1:0] rom [DEPTH];
    logic [D-1:0]  rom_v;
    logic [DW-1:0] rom_d [D];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_v <= '0;
            for (int i = 0; i < D; i++) rom_d[i] <= '0;
        end else begin
            rom_v    <= {rom_v[D-2:0], o_rom_rden};
            rom_d[0] <= rom[o_rom_addr];
            for (int i = 1; i < D; i++) rom_d[i] <= rom_d[i-1];
        end
    end
    assign i_rom_vld  = rom_v[D-1];
    assign i_rom_dout = rom_d[D-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Model: list of PCs the decoder still has to receive, in order.
    int  exp_q[$];
    bit  m_busy = 0;
    int  m_start, m_end;
    int  cyc = 0;
    int  start_cyc, first_vld_cyc, done_cyc, jmp_cyc;
    int  rden_cnt, pop_cnt;

    task automatic fill(input int s, input int e);
        int p = s;
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(p);
            if (p == e) break;
            p = (p + 1) % DEPTH;
        end
    endtask

    function automatic bit in_window(input int s, input int e, input int j);
        int p = s;
        for (int k = 0; k < DEPTH; k++) begin
            if (p == j) return 1'b1;
            if (p == e) return 1'b0;
            p = (p + 1) % DEPTH;
        end
        return 1'b0;
    endfunction

    task automatic monitor();
        int e;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 0;
            return;
        end
        if (o_rom_rden) rden_cnt++;
        if (o_inst_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_inst_vld && i_inst_rdy) begin
            pop_cnt++;
            check("pop_has_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("inst_pc", o_inst_pc, e);
                check("inst_data", o_inst_data, rom[e]);
            end
        end
        if (i_jmp_vld && m_busy) begin
            exp_q.delete();
            if (in_window(m_start, m_end, int'(i_jmp_pc))) fill(int'(i_jmp_pc), m_end);
            jmp_cyc       = cyc;
            first_vld_cyc = -1;
        end
        if (o_done) begin
            check("done_when_complete", m_busy && (exp_q.size() == 0), 1);
            done_cyc = cyc;
            m_busy   = 0;
        end
        if (i_start && !m_busy) begin
            m_busy        = 1;
            m_start       = int'(i_start_pc);
            m_end         = int'(i_end_pc);
            fill(m_start, m_end);
            start_cyc     = cyc;
            first_vld_cyc = -1;
            done_cyc      = -1;
            rden_cnt      = 0;
            pop_cnt       = 0;
        end
    endtask

    // Completes the current cycle: sample at the falling edge, return 1 after the rise.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", m_busy, 0);
    endtask

    task automatic run_prog(input logic [AW-1:0] s, input logic [AW-1:0] e, input int budget);
        i_start_pc = s;
        i_end_pc   = e;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
        wait_done(budget);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_rden"}, o_rom_rden, 0);
        check({tag, "_addr"}, o_rom_addr, 0);
        check({tag, "_ivld"}, o_inst_vld, 0);
        check({tag, "_idata"}, o_inst_data, 0);
        check({tag, "_ipc"}, o_inst_pc, 0);
    endtask

    typedef struct {
        logic [AW-1:0] spc;
        logic [AW-1:0] epc;
        int            exp_first;
        int            exp_done;
        int            exp_words;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int pops_before;

        vecs[0] = '{spc: 4'd0,  epc: 4'd7, exp_first: 4, exp_done: 12, exp_words: 8};
        vecs[1] = '{spc: 4'd14, epc: 4'd1, exp_first: 4, exp_done: 8,  exp_words: 4};
        vecs[2] = '{spc: 4'd5,  epc: 4'd5, exp_first: 4, exp_done: 5,  exp_words: 1};
        vecs[3] = '{spc: 4'd3,  epc: 4'd2, exp_first: 4, exp_done: 20, exp_words: 16};

        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h100 + i;
        rst_n = 1'b0;
        i_start = 1'b0; i_jmp_vld = 1'b0; i_inst_rdy = 1'b1;
        i_start_pc = '0; i_end_pc = '0; i_jmp_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Latency/throughput table with the decoder always ready.
        for (int v = 0; v < 4; v++) begin
            run_prog(vecs[v].spc, vecs[v].epc, 200);
            check("first_vld_latency", first_vld_cyc - start_cyc, vecs[v].exp_first);
            check("done_latency", done_cyc - start_cyc, vecs[v].exp_done);
            check("word_count", pop_cnt, vecs[v].exp_words);
            step();
        end

        // Backpressure: credit limits issue to BUF_DEPTH words.
        i_inst_rdy = 1'b0;
        i_start_pc = 4'd0; i_end_pc = 4'd11; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (20) step();
        check("stall_rden_count", rden_cnt, BD);
        check("stall_head_vld", o_inst_vld, 1);
        check("stall_head_pc", o_inst_pc, 0);
        i_inst_rdy = 1'b1;
        wait_done(200);
        check("stall_word_count", pop_cnt, 12);
        check("stall_rden_total", rden_cnt, 12);
        step();

        // Jump mid-stream with reads in flight and a word queued but not accepted.
        i_start_pc = 4'd0; i_end_pc = 4'd15; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (5) step();
        i_inst_rdy = 1'b0; i_jmp_vld = 1'b1; i_jmp_pc = 4'd10;
        pops_before = pop_cnt;
        step();
        i_jmp_vld = 1'b0; i_inst_rdy = 1'b1;
        check("jmp_first_rden", o_rom_rden, 1);
        check("jmp_first_addr", o_rom_addr, 10);
        wait_done(200);
        check("jmp_vld_latency", first_vld_cyc - jmp_cyc, 2 + D);
        check("jmp_word_count", pop_cnt - pops_before, 6);
        step();

        // Start while busy, then jump while idle: both ignored.
        i_start_pc = 4'd0; i_end_pc = 4'd9; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        i_start_pc = 4'd12; i_end_pc = 4'd13; i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_done(200);
        check("ignored_start_words", pop_cnt, 10);
        i_jmp_vld = 1'b1; i_jmp_pc = 4'd3;
        step();
        i_jmp_vld = 1'b0;
        repeat (3) step();
        check("idle_jmp_busy", o_busy, 0);
        check("idle_jmp_rden", o_rom_rden, 0);
        check("idle_jmp_addr", o_rom_addr, 10);
        check("idle_jmp_ivld", o_inst_vld, 0);

        // Asynchronous reset in the middle of a program, then a normal restart.
        i_start_pc = 4'd0; i_end_pc = 4'd15; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        run_prog(vecs[0].spc, vecs[0].epc, 200);
        check("post_reset_first_vld", first_vld_cyc - start_cyc, vecs[0].exp_first);
        check("post_reset_done", done_cyc - start_cyc, vecs[0].exp_done);
        step();

        // Random programs with random decoder stalls, jumps and ignored starts.
        for (int p = 0; p < 25; p++) begin
            int n;
            for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
            i_start_pc = AW'($urandom_range(0, DEPTH - 1));
            i_end_pc   = AW'($urandom_range(0, DEPTH - 1));
            i_start    = 1'b1;
            step();
            i_start = 1'b0;
            n = 0;
            while (m_busy && n < 2000) begin
                i_inst_rdy = ($urandom_range(0, 3) != 0);
                i_jmp_vld  = (exp_q.size() >= 2) && ($urandom_range(0, 23) == 0);
                i_jmp_pc   = AW'($urandom_range(0, DEPTH - 1));
                i_start    = (exp_q.size() >= 2) && ($urandom_range(0, 31) == 0);
                step();
                n++;
            end
            i_jmp_vld = 1'b0; i_start = 1'b0; i_inst_rdy = 1'b1;
            check("rand_done_within_budget", m_busy, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
